// File: rtl/fetch_ctrl_pkg.sv
// Shared state encodings and control-bundle type for the fetch sequencing controller.
package fetch_ctrl_pkg;

  localparam int FC_STATE_W = 3;

  typedef enum logic [FC_STATE_W-1:0] {
    FC_BOOT   = 3'd0,
    FC_RUN    = 3'd1,
    FC_DRAIN  = 3'd2,
    FC_HALT   = 3'd3,
    FC_STEP   = 3'd4,
    FC_SDRAIN = 3'd5
  } fc_state_e;

  typedef struct packed {
    logic pc_we;
    logic pc_src_sel;
    logic ifid_we;
    logic ifid_flush;
    logic idex_bubble;
    logic exmem_flush;
  } fc_ctrl_t;

  // Canned control bundles: front held with NOPs, free flow, load-use stall, MEM redirect
  localparam fc_ctrl_t FC_HOLD  = 6'b000110;
  localparam fc_ctrl_t FC_FLOW  = 6'b101000;
  localparam fc_ctrl_t FC_STALL = 6'b000010;
  localparam fc_ctrl_t FC_REDIR = 6'b110111;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Clrn,
  input  logic             inc,
  output logic [CNT_W-1:0] q
);

  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn)                q <= '0;
    else if (inc && q != '1)  q <= q + CNT_W'(1);
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: boot hold-off, redirect/halt/stall arbitration and debug stepping.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int FLUSH_DEPTH = 3,
  parameter int BOOT_CYCLES = 2,
  parameter int CNT_W       = 16
) (
  input  logic                  Clk,
  input  logic                  Clrn,
  input  logic                  MEM_PCSrc,
  input  logic                  ID_LoadUse,
  input  logic                  ID_Halt,
  input  logic                  Dbg_Run,
  input  logic                  Dbg_Step,
  output logic                  PCWe,
  output logic                  PCSrcSel,
  output logic                  IFID_We,
  output logic                  IFID_Flush,
  output logic                  IDEX_Bubble,
  output logic                  EXMEM_Flush,
  output logic [FC_STATE_W-1:0] State,
  output logic                  Halted,
  output logic [CNT_W-1:0]      StallCnt,
  output logic [CNT_W-1:0]      FlushCnt
);

  localparam int DMAX = (FLUSH_DEPTH > BOOT_CYCLES) ? FLUSH_DEPTH : BOOT_CYCLES;
  localparam int DW   = $clog2(DMAX + 1);

  fc_state_e   state_q, state_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic        run_q;
  logic        redirect, stall_inc;
  fc_ctrl_t    ctl;

  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      state_q <= FC_BOOT;
      cnt_q   <= DW'(BOOT_CYCLES - 1);
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      run_q   <= Dbg_Run;
    end
  end

  // Redirect is wrong-path-safe everywhere except while booting or parked
  assign redirect = MEM_PCSrc && (state_q == FC_RUN || state_q == FC_DRAIN ||
                                  state_q == FC_STEP || state_q == FC_SDRAIN);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ctl       = FC_HOLD;
    stall_inc = 1'b0;
    case (state_q)
      FC_BOOT: begin
        if (cnt_q == '0) state_d = Dbg_Run ? FC_RUN : FC_HALT;
        else             cnt_d   = cnt_q - DW'(1);
      end
      FC_RUN: begin
        if (redirect) begin
          state_d = FC_RUN;
        end else if (ID_Halt) begin
          state_d = FC_DRAIN;
          cnt_d   = DW'(FLUSH_DEPTH - 1);
        end else if (ID_LoadUse) begin
          ctl       = FC_STALL;
          stall_inc = 1'b1;
        end else begin
          ctl = FC_FLOW;
        end
      end
      FC_DRAIN: begin
        if (redirect)          state_d = FC_RUN;
        else if (cnt_q == '0)  state_d = FC_HALT;
        else                   cnt_d   = cnt_q - DW'(1);
      end
      FC_HALT: begin
        if (Dbg_Step)               state_d = FC_STEP;
        else if (Dbg_Run && !run_q) state_d = FC_RUN;
      end
      FC_STEP: begin
        ctl     = FC_FLOW;
        state_d = FC_SDRAIN;
        cnt_d   = DW'(FLUSH_DEPTH);
      end
      FC_SDRAIN: begin
        // The stepped instruction must retire even if a redirect lands here
        if (cnt_q == '0) state_d = FC_HALT;
        else             cnt_d   = cnt_q - DW'(1);
      end
      default: begin
        state_d = FC_BOOT;
        cnt_d   = DW'(BOOT_CYCLES - 1);
      end
    endcase
    if (redirect) ctl = FC_REDIR;
  end

  assign PCWe        = ctl.pc_we;
  assign PCSrcSel    = ctl.pc_src_sel;
  assign IFID_We     = ctl.ifid_we;
  assign IFID_Flush  = ctl.ifid_flush;
  assign IDEX_Bubble = ctl.idex_bubble;
  assign EXMEM_Flush = ctl.exmem_flush;
  assign State       = state_q;
  assign Halted      = (state_q == FC_HALT);

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .Clk(Clk), .Clrn(Clrn), .inc(stall_inc), .q(StallCnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .Clk(Clk), .Clrn(Clrn), .inc(redirect), .q(FlushCnt)
  );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed vector table, corner sequences and random run vs a phase model.
module tb_fetch_ctrl;

  localparam int FD   = 3;
  localparam int BC   = 2;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          Clk = 1'b0;
  logic          Clrn = 1'b0;
  logic          MEM_PCSrc = 1'b0, ID_LoadUse = 1'b0, ID_Halt = 1'b0;
  logic          Dbg_Run = 1'b0, Dbg_Step = 1'b0;
  logic          PCWe, PCSrcSel, IFID_We, IFID_Flush, IDEX_Bubble, EXMEM_Flush, Halted;
  logic [2:0]    State;
  logic [CW-1:0] StallCnt, FlushCnt;

  fetch_ctrl #(.FLUSH_DEPTH(FD), .BOOT_CYCLES(BC), .CNT_W(CW)) dut (
    .Clk(Clk), .Clrn(Clrn), .MEM_PCSrc(MEM_PCSrc), .ID_LoadUse(ID_LoadUse),
    .ID_Halt(ID_Halt), .Dbg_Run(Dbg_Run), .Dbg_Step(Dbg_Step),
    .PCWe(PCWe), .PCSrcSel(PCSrcSel), .IFID_We(IFID_We), .IFID_Flush(IFID_Flush),
    .IDEX_Bubble(IDEX_Bubble), .EXMEM_Flush(EXMEM_Flush), .State(State),
    .Halted(Halted), .StallCnt(StallCnt), .FlushCnt(FlushCnt)
  );

  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [6:0] dut_outs();
    return {PCWe, PCSrcSel, IFID_We, IFID_Flush, IDEX_Bubble, EXMEM_Flush, Halted};
  endfunction

  // Phase model: mode number plus cycles remaining in the timed phases
  int m_mode, m_left, m_stall, m_flush;
  bit m_prev;

  task automatic m_reset();
    m_mode = 0; m_left = BC; m_prev = 0; m_stall = 0; m_flush = 0;
  endtask

  function automatic bit m_redir(input logic [4:0] in);
    return in[4] && (m_mode == 1 || m_mode == 2 || m_mode == 4 || m_mode == 5);
  endfunction

  // in = {MEM_PCSrc, ID_LoadUse, ID_Halt, Dbg_Run, Dbg_Step}
  // out = {PCWe, PCSrcSel, IFID_We, IFID_Flush, IDEX_Bubble, EXMEM_Flush, Halted}
  function automatic logic [6:0] m_outs(input logic [4:0] in);
    logic [6:0] o;
    case (m_mode)
      1:       o = in[2] ? 7'b0001100 : (in[3] ? 7'b0000100 : 7'b1010000);
      3:       o = 7'b0001101;
      4:       o = 7'b1010000;
      default: o = 7'b0001100;
    endcase
    if (m_redir(in)) o = 7'b1101110;
    return o;
  endfunction

  task automatic m_adv(input logic [4:0] in);
    bit r;
    r = m_redir(in);
    if (r && m_flush < CMAX) m_flush++;
    case (m_mode)
      0: begin m_left--; if (m_left == 0) m_mode = in[1] ? 1 : 3; end
      1: if (!r) begin
           if (in[2]) begin m_mode = 2; m_left = FD; end
           else if (in[3] && m_stall < CMAX) m_stall++;
         end
      2: if (r) m_mode = 1;
         else begin m_left--; if (m_left == 0) m_mode = 3; end
      3: if (in[0]) m_mode = 4;
         else if (in[1] && !m_prev) m_mode = 1;
      4: begin m_mode = 5; m_left = FD + 1; end
      5: begin m_left--; if (m_left == 0) m_mode = 3; end
      default: m_mode = 0;
    endcase
    m_prev = in[1];
  endtask

  // Drive at posedge+1, check mid-cycle, then advance across the next edge
  task automatic drive_check(input logic [4:0] in);
    {MEM_PCSrc, ID_LoadUse, ID_Halt, Dbg_Run, Dbg_Step} = in;
    #2;
    chk("model_outs", {25'd0, dut_outs()}, {25'd0, m_outs(in)});
    chk("model_state_cnt", {21'd0, State, StallCnt, FlushCnt},
        {21'd0, 3'(m_mode), CW'(m_stall), CW'(m_flush)});
  endtask

  task automatic tick(input logic [4:0] in);
    @(posedge Clk);
    m_adv(in);
    #1;
  endtask

  task automatic apply(input logic [4:0] in);
    drive_check(in);
    tick(in);
  endtask

  task automatic do_reset();
    Clrn = 1'b0;
    {MEM_PCSrc, ID_LoadUse, ID_Halt, Dbg_Run, Dbg_Step} = 5'b00010;
    m_reset();
    @(posedge Clk); #1;
    Clrn = 1'b1;
  endtask

  typedef struct {
    logic [4:0] in;
    logic [6:0] eo;
    logic [2:0] st;
    int         stall;
    int         flush;
  } vec_t;

  vec_t tbl[26];

  initial begin
    tbl[0]  = '{5'b00010, 7'b0001100, 3'd0, 0, 0};
    tbl[1]  = '{5'b00010, 7'b0001100, 3'd0, 0, 0};
    tbl[2]  = '{5'b00010, 7'b1010000, 3'd1, 0, 0};
    tbl[3]  = '{5'b00010, 7'b1010000, 3'd1, 0, 0};
    tbl[4]  = '{5'b01010, 7'b0000100, 3'd1, 0, 0};
    tbl[5]  = '{5'b00010, 7'b1010000, 3'd1, 1, 0};
    tbl[6]  = '{5'b11110, 7'b1101110, 3'd1, 1, 0};
    tbl[7]  = '{5'b00010, 7'b1010000, 3'd1, 1, 1};
    tbl[8]  = '{5'b00110, 7'b0001100, 3'd1, 1, 1};
    tbl[9]  = '{5'b00010, 7'b0001100, 3'd2, 1, 1};
    tbl[10] = '{5'b00010, 7'b0001100, 3'd2, 1, 1};
    tbl[11] = '{5'b00010, 7'b0001100, 3'd2, 1, 1};
    tbl[12] = '{5'b00010, 7'b0001101, 3'd3, 1, 1};
    tbl[13] = '{5'b00011, 7'b0001101, 3'd3, 1, 1};
    tbl[14] = '{5'b00010, 7'b1010000, 3'd4, 1, 1};
    tbl[15] = '{5'b00010, 7'b0001100, 3'd5, 1, 1};
    tbl[16] = '{5'b00010, 7'b0001100, 3'd5, 1, 1};
    tbl[17] = '{5'b00010, 7'b0001100, 3'd5, 1, 1};
    tbl[18] = '{5'b00010, 7'b0001100, 3'd5, 1, 1};
    tbl[19] = '{5'b00000, 7'b0001101, 3'd3, 1, 1};
    tbl[20] = '{5'b00010, 7'b0001101, 3'd3, 1, 1};
    tbl[21] = '{5'b00010, 7'b1010000, 3'd1, 1, 1};
    tbl[22] = '{5'b00110, 7'b0001100, 3'd1, 1, 1};
    tbl[23] = '{5'b00010, 7'b0001100, 3'd2, 1, 1};
    tbl[24] = '{5'b10010, 7'b1101110, 3'd2, 1, 1};
    tbl[25] = '{5'b00010, 7'b1010000, 3'd1, 1, 2};

    // Reset values while Clrn is held low
    m_reset();
    #2;
    chk("reset_outs", {25'd0, dut_outs()}, {25'd0, 7'b0001100});
    chk("reset_state", {29'd0, State}, 32'd0);
    chk("reset_cnts", {24'd0, StallCnt, FlushCnt}, 32'd0);

    do_reset();
    foreach (tbl[i]) begin
      drive_check(tbl[i].in);
      chk($sformatf("tbl%0d_outs", i), {25'd0, dut_outs()}, {25'd0, tbl[i].eo});
      chk($sformatf("tbl%0d_state", i), {29'd0, State}, {29'd0, tbl[i].st});
      chk($sformatf("tbl%0d_cnts", i), {24'd0, StallCnt, FlushCnt},
          {24'd0, CW'(tbl[i].stall), CW'(tbl[i].flush)});
      tick(tbl[i].in);
    end

    // Async reset in the middle of a single-step drain
    apply(5'b00110);
    repeat (3) apply(5'b00010);
    apply(5'b00010);
    apply(5'b00011);
    apply(5'b00010);
    apply(5'b00010);
    {MEM_PCSrc, ID_LoadUse, ID_Halt, Dbg_Run, Dbg_Step} = 5'b00010;
    #2;
    chk("pre_rst_sdrain", {29'd0, State}, 32'd5);
    Clrn = 1'b0;
    #1;
    chk("async_rst_state", {29'd0, State}, 32'd0);
    chk("async_rst_outs", {25'd0, dut_outs()}, {25'd0, 7'b0001100});
    chk("async_rst_cnts", {24'd0, StallCnt, FlushCnt}, 32'd0);
    m_reset();
    @(posedge Clk); #1;
    Clrn = 1'b1;
    drive_check(5'b00010); chk("reboot_pcwe0", {31'd0, PCWe}, 32'd0); tick(5'b00010);
    drive_check(5'b00010); chk("reboot_pcwe1", {31'd0, PCWe}, 32'd0); tick(5'b00010);
    drive_check(5'b00010); chk("reboot_pcwe2", {31'd0, PCWe}, 32'd1); tick(5'b00010);

    // Held load-use: stall persists and the counter saturates
    repeat (CMAX + 5) begin
      drive_check(5'b01010);
      chk("held_stall_pcwe", {31'd0, PCWe}, 32'd0);
      tick(5'b01010);
    end
    #2;
    chk("stall_saturated", {28'd0, StallCnt}, CMAX);
    #1;

    // Boot into HALT with Dbg_Run low, then resume on its rising edge
    Clrn = 1'b0;
    m_reset();
    @(posedge Clk); #1;
    Clrn = 1'b1;
    apply(5'b00000);
    apply(5'b00000);
    drive_check(5'b00000); chk("boot_to_halt", {31'd0, Halted}, 32'd1); tick(5'b00000);
    apply(5'b00010);
    drive_check(5'b00010); chk("run_edge_resume", {29'd0, State}, 32'd1); tick(5'b00010);

    // Randomised traffic against the phase model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      logic [4:0] in;
      in[4] = ($urandom_range(99) < 12);
      in[3] = ($urandom_range(99) < 30);
      in[2] = ($urandom_range(99) < 8);
      in[1] = ($urandom_range(99) < 85);
      in[0] = ($urandom_range(99) < 10);
      apply(in);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
